pipe_stage: RTL and testbench

Parametrised inter-stage pipeline register carrying one payload word per beat between adjacent CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a valid/ready handshake for stalls, a flush input for squashing wrong-path instructions, and a saturating stall counter. An optional two-entry skid mode gives a registered upstream ready. Stage-specific fields (PC+4, operands, instruction, decoded name, destination register, ALU source, extended immediate) are packed by the instantiating stage into one `in_data` vector.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_slot.sv | 27 ++
 rtl/pipe_stage.sv | 108 ++++++++++
 tb/tb_pipe_stage.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for inter-stage pipeline registers: occupancy
// states and the field layout of the packed ID/EX bundle.
package pipe_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_t;

  localparam int ID_EX_W = 174;

  // ID/EX bundle, LSB first: imm | alu_src | rd | name | instr | op_b | op_a | pc4
  localparam int IMM_LSB    = 0;
  localparam int ALUSRC_LSB = 32;
  localparam int RD_LSB     = 33;
  localparam int NAME_LSB   = 38;
  localparam int INSTR_LSB  = 46;
  localparam int OPB_LSB    = 78;
  localparam int OPA_LSB    = 110;
  localparam int PC4_LSB    = 142;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag plus payload register. clr beats load on the
// flag; the payload only ever changes on load.
module pipe_slot #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= RST_DATA;
    end else begin
      if (clr)       valid <= 1'b0;
      else if (load) valid <= 1'b1;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Inter-stage pipeline register with valid/ready, flush and saturating stall
// counter. Define PIPE_STAGE_SKID_EN for the two-entry registered-ready variant.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = ID_EX_W,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic in_fire, out_fire;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  pipe_state_t       state, state_nxt;
  logic              m_load, m_clr, s_load, s_clr, s_valid;
  logic [DATA_W-1:0] m_d, s_q;

  // A parked skid beat always has priority for the main slot.
  assign m_d = s_valid ? s_q : in_data;

  pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_main (
    .clk(clk), .rst(rst), .load(m_load), .clr(m_clr), .d(m_d),
    .valid(out_valid), .q(out_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_skid (
    .clk(clk), .rst(rst), .load(s_load), .clr(s_clr), .d(in_data),
    .valid(s_valid), .q(s_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_load    = 1'b0;
    m_clr     = 1'b0;
    s_load    = 1'b0;
    s_clr     = 1'b0;
    unique case (state)
      EMPTY: if (in_fire) begin
        m_load    = 1'b1;
        state_nxt = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          m_load = 1'b1;
        end else if (in_fire) begin
          s_load    = 1'b1;
          state_nxt = TWO;
        end else if (out_fire) begin
          m_clr     = 1'b1;
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        m_load    = 1'b1;
        s_clr     = 1'b1;
        state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      m_load    = 1'b0;
      s_load    = 1'b0;
      m_clr     = 1'b1;
      s_clr     = 1'b1;
      state_nxt = EMPTY;
    end
  end

  assign in_ready = (state != TWO);
`else
  logic load, clr;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_fire && !flush;
  assign clr      = flush || (out_fire && !in_fire);

  pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_main (
    .clk(clk), .rst(rst), .load(load), .clr(clr), .d(in_data),
    .valid(out_valid), .q(out_data)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage; expectations follow the build mode
// (PIPE_STAGE_SKID_EN defined or not).
module tb_pipe_stage;

  localparam int DW = 174;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [DW-1:0] RST_D = 174'h5A5;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0] in_data, out_data;
  logic [15:0]   stall_cnt;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]    s_in_data, s_out_data;
  logic [3:0]    s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit b_taken;

  pipe_stage #(.DATA_W(DW), .CNT_W(16), .RST_DATA(RST_D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .stall_cnt(stall_cnt)
  );

  pipe_stage #(.DATA_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .flush(1'b0), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0; rst = 1; flush = 0;
    in_valid = 0; in_data = '0; out_ready = 0;
    s_in_valid = 0; s_in_data = 8'h3C; s_out_ready = 0;

    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, RST_D);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 0;

    // streaming 0x1..0x8, one-cycle latency
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      out_ready = 1;
      in_valid  = (k < 8);
      in_data   = DW'(k + 1);
      #1;
      if (k < 8) chk("stream_in_ready", in_ready, 1);
      chk("stream_out_valid", out_valid, (k >= 1 && k <= 8));
      if (k >= 1 && k <= 8) chk("stream_out_data", out_data, DW'(k));
    end
    chk("stream_stall_cnt", stall_cnt, 0);

    // backpressure: A held for 3 stalled cycles while B is offered
    @(negedge clk);
    in_valid = 1; in_data = 'hA; out_ready = 1;
    b_taken = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      out_ready = 0;
      in_valid  = !b_taken;
      in_data   = 'hB;
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 'hA);
      chk("bp_in_ready", in_ready, SKID && (i == 1));
      if (in_valid && in_ready) b_taken = 1;
    end
    @(negedge clk);
    out_ready = 1;
    in_valid  = !b_taken;
    #1;
    chk("bp_stall_cnt", stall_cnt, 3);
    chk("bp_hold_a", out_data, 'hA);
    chk("bp_in_ready_release", in_ready, !SKID);
    if (in_valid && in_ready) b_taken = 1;
    chk("bp_b_taken", b_taken, 1);

    // flush with B held and C offered in the same cycle
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_data = 'hC; flush = 1;
    #1;
    chk("order_b", out_data, 'hB);
    chk("order_b_valid", out_valid, 1);
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 1;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(negedge clk);
    #1;
    chk("flush_out_valid2", out_valid, 0);
    chk("flush_stall_cnt", stall_cnt, 3);

    // asynchronous reset mid-stream
    @(negedge clk);
    in_valid = 1; in_data = 'h11; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("pre_rst_data", out_data, 'h11);
    @(posedge clk);
    #2;
    chk("pre_rst_stall", stall_cnt, 4);
    rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, RST_D);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk); rst = 0;

    // stall counter saturation at CNT_W=4
    @(negedge clk);
    s_in_valid = 1; s_out_ready = 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      s_in_valid = 0;
      #1;
      if (k == 1)  chk("sat_out_valid", s_out_valid, 1);
      if (k == 15) chk("sat_14", s_stall_cnt, 14);
      if (k == 16) chk("sat_15", s_stall_cnt, 15);
      if (k == 21) chk("sat_hold", s_stall_cnt, 15);
    end
    chk("sat_data", s_out_data, 'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
